// File: rtl/m_unit_scheduler.sv
// m_unit_scheduler: issues one MUL/DIV op at a time to the multi-cycle
// M-extension units, tracks its destination as a one-entry scoreboard,
// stalls the front-end on RAW/WAW/structural hazards and claims one EX
// output slot to write the result back.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ex_valid/ex_is_m/ex_func3      EX instruction qualifiers and M op select
//   ex_rd/ex_rs1/ex_rs2            EX register indices
//   ex_wb_reg_file                 EX instruction writes rd via the ALU path
//   ex_op1/ex_op2                  forwarded operands
//   pipeline_flush                 branch/jump flush of younger instructions
//   mul_start/div_start            one-cycle start pulses to the units
//   unit_op/unit_a/unit_b          latched func3 and operands
//   mul_done/div_done/unit_result  unit completion and result
//   m_unit_ready/wr/dest/result    writeback slot into the EX/MEM register
//   stall                          front-end freeze (combinational)
//   busy                           op in flight
//   stall_cycles                   saturating count of stalled cycles
module m_unit_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_is_m,
    input  logic [2:0]            ex_func3,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  ex_wb_reg_file,
    input  logic [DATA_WIDTH-1:0] ex_op1,
    input  logic [DATA_WIDTH-1:0] ex_op2,
    input  logic                  pipeline_flush,
    output logic                  mul_start,
    output logic                  div_start,
    output logic [2:0]            unit_op,
    output logic [DATA_WIDTH-1:0] unit_a,
    output logic [DATA_WIDTH-1:0] unit_b,
    input  logic                  mul_done,
    input  logic                  div_done,
    input  logic [DATA_WIDTH-1:0] unit_result,
    output logic                  m_unit_ready,
    output logic                  m_unit_wr,
    output logic [REG_ADDR_W-1:0] m_unit_dest,
    output logic [DATA_WIDTH-1:0] m_unit_result,
    output logic                  stall,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_WB       = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            unit_op_q, unit_op_d;
    logic [REG_ADDR_W-1:0] p_rd_q, p_rd_d;
    logic [DATA_WIDTH-1:0] unit_a_q, unit_a_d;
    logic [DATA_WIDTH-1:0] unit_b_q, unit_b_d;
    logic                  mul_start_q, mul_start_d;
    logic                  div_start_q, div_start_d;
    logic                  wb_ready_q, wb_ready_d;
    logic                  wb_wr_q, wb_wr_d;
    logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_WIDTH-1:0] wb_result_q, wb_result_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;

    logic waiting_c;
    logic hazard_c;
    logic stall_c;
    logic issue_c;

    // Hazard detection against the single outstanding destination
    always_comb begin
        waiting_c = (state_q == S_MUL_WAIT) || (state_q == S_DIV_WAIT);
        hazard_c  = waiting_c && ex_valid && (p_rd_q != '0) &&
                    ((ex_rs1 == p_rd_q) ||
                     (ex_rs2 == p_rd_q) ||
                     (ex_wb_reg_file && (ex_rd == p_rd_q)) ||
                     ex_is_m);
        stall_c   = hazard_c || (state_q == S_WB);
        issue_c   = (state_q == S_IDLE) && ex_valid && ex_is_m &&
                    !pipeline_flush && !stall_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        unit_op_d      = unit_op_q;
        p_rd_d         = p_rd_q;
        unit_a_d       = unit_a_q;
        unit_b_d       = unit_b_q;
        mul_start_d    = 1'b0;
        div_start_d    = 1'b0;
        wb_ready_d     = 1'b0;
        wb_wr_d        = 1'b0;
        wb_dest_d      = '0;
        wb_result_d    = '0;
        stall_cycles_d = stall_cycles_q;

        case (state_q)
            S_IDLE: begin
                if (issue_c) begin
                    unit_op_d   = ex_func3;
                    p_rd_d      = ex_rd;
                    unit_a_d    = ex_op1;
                    unit_b_d    = ex_op2;
                    mul_start_d = !ex_func3[2];
                    div_start_d = ex_func3[2];
                    state_d     = ex_func3[2] ? S_DIV_WAIT : S_MUL_WAIT;
                end
            end
            // Only the awaited unit's done is honoured
            S_MUL_WAIT: begin
                if (mul_done) begin
                    state_d     = S_WB;
                    wb_ready_d  = 1'b1;
                    wb_wr_d     = (p_rd_q != '0);
                    wb_dest_d   = p_rd_q;
                    wb_result_d = unit_result;
                end
            end
            S_DIV_WAIT: begin
                if (div_done) begin
                    state_d     = S_WB;
                    wb_ready_d  = 1'b1;
                    wb_wr_d     = (p_rd_q != '0);
                    wb_dest_d   = p_rd_q;
                    wb_result_d = unit_result;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        // Saturating stall counter
        if (stall_c && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            unit_op_q      <= '0;
            p_rd_q         <= '0;
            unit_a_q       <= '0;
            unit_b_q       <= '0;
            mul_start_q    <= 1'b0;
            div_start_q    <= 1'b0;
            wb_ready_q     <= 1'b0;
            wb_wr_q        <= 1'b0;
            wb_dest_q      <= '0;
            wb_result_q    <= '0;
            busy_q         <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            unit_op_q      <= unit_op_d;
            p_rd_q         <= p_rd_d;
            unit_a_q       <= unit_a_d;
            unit_b_q       <= unit_b_d;
            mul_start_q    <= mul_start_d;
            div_start_q    <= div_start_d;
            wb_ready_q     <= wb_ready_d;
            wb_wr_q        <= wb_wr_d;
            wb_dest_q      <= wb_dest_d;
            wb_result_q    <= wb_result_d;
            busy_q         <= busy_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mul_start     = mul_start_q;
    assign div_start     = div_start_q;
    assign unit_op       = unit_op_q;
    assign unit_a        = unit_a_q;
    assign unit_b        = unit_b_q;
    assign m_unit_ready  = wb_ready_q;
    assign m_unit_wr     = wb_wr_q;
    assign m_unit_dest   = wb_dest_q;
    assign m_unit_result = wb_result_q;
    assign stall         = stall_c;
    assign busy          = busy_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_m_unit_scheduler.sv
// tb_m_unit_scheduler: randomized + directed bench for m_unit_scheduler.
// The bench plays the role of the pipeline and of both M units; expected
// start requests and writebacks are queued at issue and checked by a
// separate monitor when the DUT presents them.
`timescale 1ns/1ps
module tb_m_unit_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 32;

    logic          clk;
    logic          rst_n;
    logic          ex_valid, ex_is_m, ex_wb_reg_file, pipeline_flush;
    logic [2:0]    ex_func3;
    logic [RW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic [DW-1:0] ex_op1, ex_op2;
    logic          mul_start, div_start;
    logic [2:0]    unit_op;
    logic [DW-1:0] unit_a, unit_b;
    logic          mul_done, div_done;
    logic [DW-1:0] unit_result;
    logic          m_unit_ready, m_unit_wr;
    logic [RW-1:0] m_unit_dest;
    logic [DW-1:0] m_unit_result;
    logic          stall, busy;
    logic [CW-1:0] stall_cycles;

    m_unit_scheduler #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_m(ex_is_m), .ex_func3(ex_func3),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_wb_reg_file(ex_wb_reg_file), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .pipeline_flush(pipeline_flush),
        .mul_start(mul_start), .div_start(div_start), .unit_op(unit_op),
        .unit_a(unit_a), .unit_b(unit_b),
        .mul_done(mul_done), .div_done(div_done), .unit_result(unit_result),
        .m_unit_ready(m_unit_ready), .m_unit_wr(m_unit_wr),
        .m_unit_dest(m_unit_dest), .m_unit_result(m_unit_result),
        .stall(stall), .busy(busy), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        div;
        bit [2:0]  op;
        bit [31:0] a;
        bit [31:0] b;
    } start_t;

    typedef struct {
        bit        wr;
        bit [4:0]  dest;
        bit [31:0] res;
    } wb_t;

    typedef struct {
        bit        v;
        bit        m;
        bit [2:0]  f3;
        bit [4:0]  rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit        wb;
        bit [31:0] a;
        bit [31:0] b;
        bit        flush;
    } instr_t;

    start_t start_q[$];
    wb_t    wb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference model: one pending op, its destination and remaining latency
    bit        pend, pend_div, wb_phase;
    bit [4:0]  prd;
    bit [31:0] pend_res;
    int        done_in;
    int        lat_cfg;
    bit        exp_mul_s, exp_div_s;
    bit [31:0] exp_cnt;
    bit        last_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // M-extension arithmetic from the ISA definition
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: return a * b;
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic instr_t mk(input bit v, input bit m, input bit [2:0] f3,
                                  input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                                  input bit wb, input bit [31:0] a, input bit [31:0] b,
                                  input bit flush);
        instr_t i;
        i.v = v; i.m = m; i.f3 = f3; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.wb = wb; i.a = a; i.b = b; i.flush = flush;
        return i;
    endfunction

    task automatic clear_model();
        pend = 1'b0; pend_div = 1'b0; wb_phase = 1'b0; prd = 5'd0;
        pend_res = 32'd0; done_in = 0; exp_mul_s = 1'b0; exp_div_s = 1'b0;
        exp_cnt = 32'd0; last_stall = 1'b0;
        start_q.delete();
        wb_q.delete();
    endtask

    // One clock cycle: drive EX and unit responses, check stall/status, advance model
    task automatic step(input instr_t i);
        bit done_now;
        bit haz;
        bit exp_stall;
        @(negedge clk);
        ex_valid       = i.v;
        ex_is_m        = i.m;
        ex_func3       = i.f3;
        ex_rd          = i.rd;
        ex_rs1         = i.rs1;
        ex_rs2         = i.rs2;
        ex_wb_reg_file = i.wb;
        ex_op1         = i.a;
        ex_op2         = i.b;
        pipeline_flush = i.flush;
        done_now = pend && !wb_phase && (done_in == 0);
        mul_done = done_now && !pend_div;
        div_done = done_now && pend_div;
        // The other unit's done must be ignored
        if (pend && !wb_phase && !done_now && ($urandom_range(3) == 0)) begin
            if (pend_div) mul_done = 1'b1;
            else          div_done = 1'b1;
        end
        unit_result = done_now ? pend_res : $urandom;
        #1;
        haz = pend && !wb_phase && i.v && (prd != 5'd0) &&
              ((i.rs1 == prd) || (i.rs2 == prd) || (i.wb && (i.rd == prd)) || i.m);
        exp_stall = wb_phase || haz;
        check("stall", 64'(stall), 64'(exp_stall));
        check("busy", 64'(busy), 64'(pend));
        check("mul_start_pulse", 64'(mul_start), 64'(exp_mul_s));
        check("div_start_pulse", 64'(div_start), 64'(exp_div_s));
        check("m_unit_ready", 64'(m_unit_ready), 64'(wb_phase));
        check("stall_cycles", 64'(stall_cycles), 64'(exp_cnt));
        last_stall = exp_stall;

        if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        exp_mul_s = 1'b0;
        exp_div_s = 1'b0;
        if (wb_phase) begin
            wb_phase = 1'b0;
            pend     = 1'b0;
        end else if (pend) begin
            if (done_now) wb_phase = 1'b1;
            else          done_in--;
        end else if (i.v && i.m && !i.flush) begin
            pend      = 1'b1;
            pend_div  = i.f3[2];
            prd       = i.rd;
            done_in   = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
            pend_res  = ref_result(i.f3, i.a, i.b);
            exp_mul_s = !i.f3[2];
            exp_div_s = i.f3[2];
            start_q.push_back('{i.f3[2], i.f3, i.a, i.b});
            wb_q.push_back('{(i.rd != 5'd0), i.rd, pend_res});
        end
    endtask

    // Present an instruction, holding it in EX while stalled
    task automatic run(input instr_t i);
        int n;
        n = 0;
        do begin
            step(i);
            n++;
        end while (last_stall && n < 64);
        if (last_stall) fail_now("replay_timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pend && n < 32) begin
            step(mk(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 32'd0, 0));
            n++;
        end
        if (pend) fail_now("drain_timeout");
        step(mk(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 32'd0, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_is_m = 1'b0; ex_func3 = 3'd0; ex_rd = '0; ex_rs1 = '0;
        ex_rs2 = '0; ex_wb_reg_file = 1'b0; ex_op1 = '0; ex_op2 = '0;
        pipeline_flush = 1'b0; mul_done = 1'b0; div_done = 1'b0; unit_result = '0;
        #1;
        check("rst_starts", 64'({mul_start, div_start}), 64'd0);
        check("rst_unit_op", 64'(unit_op), 64'd0);
        check("rst_unit_a", 64'(unit_a), 64'd0);
        check("rst_unit_b", 64'(unit_b), 64'd0);
        check("rst_wb_flags", 64'({m_unit_ready, m_unit_wr, m_unit_dest}), 64'd0);
        check("rst_wb_result", 64'(m_unit_result), 64'd0);
        check("rst_stall_busy", 64'({stall, busy}), 64'd0);
        check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pop expectations whenever the DUT presents a start or a writeback
    start_t se;
    wb_t    we;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (mul_start || div_start) begin
                if (start_q.size() == 0) begin
                    fail_now("start_unexpected");
                end else begin
                    se = start_q.pop_front();
                    check("start_unit", 64'({mul_start, div_start}),
                          se.div ? 64'd1 : 64'd2);
                    check("unit_op", 64'(unit_op), 64'(se.op));
                    check("unit_a", 64'(unit_a), 64'(se.a));
                    check("unit_b", 64'(unit_b), 64'(se.b));
                end
            end
            if (m_unit_ready) begin
                if (wb_q.size() == 0) begin
                    fail_now("wb_unexpected");
                end else begin
                    we = wb_q.pop_front();
                    check("m_unit_wr", 64'(m_unit_wr), 64'(we.wr));
                    check("m_unit_dest", 64'(m_unit_dest), 64'(we.dest));
                    check("m_unit_result", 64'(m_unit_result), 64'(we.res));
                end
            end else begin
                check("wb_idle_zero", 64'({m_unit_wr, m_unit_dest}) | 64'(m_unit_result), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t ri;
        rst_n = 1'b0;
        clear_model();
        lat_cfg = 2;
        do_reset();

        // MUL x5 = 7*6
        run(mk(1, 1, 3'd0, 5'd5, 5'd1, 5'd2, 0, 32'd7, 32'd6, 0));
        drain();

        // DIVU x3 in flight, dependent ADD rs1=x3 stalls until WB then replays
        run(mk(1, 1, 3'd5, 5'd3, 5'd1, 5'd2, 0, 32'd100, 32'd7, 0));
        run(mk(1, 0, 3'd0, 5'd6, 5'd3, 5'd2, 1, 32'd0, 32'd0, 0));
        drain();

        // Independent ADD x4 no stall; WAW ADD to x3 stalls
        lat_cfg = 4;
        run(mk(1, 1, 3'd4, 5'd3, 5'd1, 5'd2, 0, 32'hFFFF_FF9C, 32'd7, 0));
        run(mk(1, 0, 3'd0, 5'd4, 5'd1, 5'd2, 1, 32'd0, 32'd0, 0));
        run(mk(1, 0, 3'd0, 5'd3, 5'd1, 5'd2, 1, 32'd0, 32'd0, 0));
        drain();

        // MUL to x0: writeback slot claimed with no register write
        lat_cfg = 1;
        run(mk(1, 1, 3'd0, 5'd0, 5'd1, 5'd2, 0, 32'd3, 32'd9, 0));
        drain();

        // Back-to-back MULs: the second waits and issues right after WB
        lat_cfg = 3;
        run(mk(1, 1, 3'd1, 5'd7, 5'd1, 5'd2, 0, 32'h8000_0000, 32'd3, 0));
        run(mk(1, 1, 3'd3, 5'd8, 5'd1, 5'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0));
        drain();

        // Flushed M op in IDLE never starts
        run(mk(1, 1, 3'd0, 5'd9, 5'd1, 5'd2, 0, 32'd5, 32'd5, 1));
        drain();

        // Flush during DIV_WAIT does not cancel the divide
        run(mk(1, 1, 3'd6, 5'd10, 5'd1, 5'd2, 0, 32'd17, 32'd0, 0));
        step(mk(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 32'd0, 1));
        step(mk(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 32'd0, 1));
        drain();

        // Reset while a divide is in flight
        lat_cfg = 4;
        run(mk(1, 1, 3'd7, 5'd11, 5'd1, 5'd2, 0, 32'd50, 32'd6, 0));
        step(mk(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 32'd0, 0));
        do_reset();
        drain();

        // Randomized traffic with small register indices to provoke hazards
        lat_cfg = 0;
        for (int n = 0; n < 400; n++) begin
            ri.v     = ($urandom_range(3) != 0);
            ri.m     = ri.v && ($urandom_range(3) == 0);
            ri.f3    = 3'($urandom_range(7));
            ri.rd    = 5'($urandom_range(7));
            ri.rs1   = 5'($urandom_range(7));
            ri.rs2   = 5'($urandom_range(7));
            ri.wb    = !ri.m && ($urandom_range(1) == 1);
            ri.a     = $urandom;
            ri.b     = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            ri.flush = ($urandom_range(7) == 0);
            run(ri);
            if ($urandom_range(149) == 0) do_reset();
        end
        drain();

        check("start_queue_empty", 64'(start_q.size()), 64'd0);
        check("wb_queue_empty", 64'(wb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
